uengine_spi_master: RTL and testbench

SPI master that executes one 32-bit command frame per request on behalf of the uEngine control stages (engine status checker, job loader, nonce reader). It consumes the `SPI_TX`/`SPI_START` handshake those stages drive and returns `SPI_RX`/`SPI_DONE`. It drives the ASIC chain's chip-select, serial clock and MOSI, and captures MISO. It is the only owner of the physical SPI pins; the arbitration between client stages sits upstream of it.

---
 rtl/uengine_spi_pkg.sv | 24 ++
 rtl/uengine_spi_tick.sv | 26 ++
 rtl/uengine_spi_master.sv | 141 ++++++++++++++
 tb/tb_uengine_spi_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uengine_spi_pkg.sv
// Shared definitions for the uEngine SPI master.
// Holds the FSM state encoding, frame geometry and the command-frame
// field offsets used by the client stages that build SPI_TX words.
package uengine_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } SpiState;

  localparam int FRAME_BITS = 32;
  localparam int RX_BITS    = 16;

  // Command frame layout: {op, chip[2:0], engine[3:0], reg[7:0], data[15:0]}
  localparam int OP_BIT     = 31;
  localparam int CHIP_LSB   = 28;
  localparam int ENGINE_LSB = 24;
  localparam int REG_LSB    = 16;

endpackage

// File: rtl/uengine_spi_tick.sv
// Half-period timer for the SPI master.
// Ports:
//   SysClock, SysReset_n : clock, async active-low reset
//   load                 : reload the counter with loadVal
//   loadVal[7:0]         : reload value (half-period minus one)
//   tick                 : high while the count is zero (phase may change)
module uengine_spi_tick (
  input  logic       SysClock,
  input  logic       SysReset_n,
  input  logic       load,
  input  logic [7:0] loadVal,
  output logic       tick
);

  logic [7:0] count;

  always_ff @(posedge SysClock or negedge SysReset_n) begin
    if (!SysReset_n)        count <= 8'd0;
    else if (load)          count <= loadVal;
    else if (count != 8'd0) count <= count - 8'd1;
  end

  // The owner reloads on the same edge it acts on tick, so tick lasts one cycle.
  assign tick = (count == 8'd0);

endmodule

// File: rtl/uengine_spi_master.sv
// uEngine SPI master: runs one 32-bit command frame per request (mode 0,
// MSB first) and returns the MISO bits sampled on the last 16 SCLK rises.
// Ports:
//   SysClock, SysReset_n  : clock, async active-low reset
//   SPI_TX[31:0]          : command frame, latched when a frame starts
//   SPI_START             : request, sampled only while idle
//   SPI_RX[15:0]          : returned data, valid with SPI_DONE
//   SPI_DONE              : one-cycle completion pulse
//   Busy                  : high whenever a frame is in progress
//   SPI_CS_n/SCLK/MOSI    : physical SPI outputs
//   SPI_MISO              : physical SPI input (registered once)
//   DebugExport[31:0]     : {22'b0, state, bit_count, sclk}
module uengine_spi_master
  import uengine_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  SysClock,
  input  logic                  SysReset_n,
  input  logic [FRAME_BITS-1:0] SPI_TX,
  input  logic                  SPI_START,
  output logic [RX_BITS-1:0]    SPI_RX,
  output logic                  SPI_DONE,
  output logic                  Busy,
  output logic                  SPI_CS_n,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  output logic [31:0]           DebugExport
);

  localparam logic [7:0] HALF_M1 = 8'(CLK_DIV - 1);

  SpiState               state, nextState;
  logic [FRAME_BITS-2:0] shiftReg;  // bits still to send after the current MOSI bit
  logic [RX_BITS-1:0]    capture, rxReg;
  logic [5:0]            bitCount;
  logic                  csN, sclk, mosi, doneReg, misoSync, capPend;
  logic                  tick, divLoad, accept, riseStb, fallStb, finStb;

  uengine_spi_tick uTick (
    .SysClock   (SysClock),
    .SysReset_n (SysReset_n),
    .load       (divLoad),
    .loadVal    (HALF_M1),
    .tick       (tick)
  );

  always_ff @(posedge SysClock or negedge SysReset_n) begin
    if (!SysReset_n) state <= ST_IDLE;
    else             state <= nextState;
  end

  always_comb begin
    nextState = state;
    divLoad   = 1'b0;
    accept    = 1'b0;
    riseStb   = 1'b0;
    fallStb   = 1'b0;
    finStb    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Keep the timer primed so SETUP lasts exactly H cycles.
        divLoad = 1'b1;
        if (SPI_START) begin
          accept    = 1'b1;
          nextState = ST_SETUP;
        end
      end
      ST_SETUP, ST_SHIFT_LO: if (tick) begin
        divLoad   = 1'b1;
        riseStb   = 1'b1;
        nextState = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: if (tick) begin
        divLoad   = 1'b1;
        fallStb   = 1'b1;
        nextState = (bitCount == 6'(FRAME_BITS - 1)) ? ST_HOLD : ST_SHIFT_LO;
      end
      ST_HOLD: if (tick) begin
        divLoad   = 1'b1;
        finStb    = 1'b1;
        nextState = ST_DONE;
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge SysClock or negedge SysReset_n) begin
    if (!SysReset_n) begin
      misoSync <= 1'b0;
      capPend  <= 1'b0;
      shiftReg <= '0;
      capture  <= '0;
      rxReg    <= '0;
      bitCount <= 6'd0;
      csN      <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      misoSync <= SPI_MISO;
      doneReg  <= finStb;
      // Capture one cycle after the rise so the bit taken is the one the
      // synchroniser registered on the rise edge itself.
      capPend  <= riseStb;
      if (capPend) capture <= {capture[RX_BITS-2:0], misoSync};
      if (accept) begin
        shiftReg <= SPI_TX[FRAME_BITS-2:0];
        mosi     <= SPI_TX[OP_BIT];
        csN      <= 1'b0;
        bitCount <= 6'd0;
        capture  <= '0;
      end
      if (riseStb) sclk <= 1'b1;
      if (fallStb) begin
        sclk     <= 1'b0;
        bitCount <= bitCount + 6'd1;
        if (bitCount != 6'(FRAME_BITS - 1)) begin
          mosi     <= shiftReg[FRAME_BITS-2];
          shiftReg <= {shiftReg[FRAME_BITS-3:0], 1'b0};
        end
      end
      if (finStb) begin
        csN   <= 1'b1;
        mosi  <= 1'b0;
        rxReg <= capture;
      end
    end
  end

  assign SPI_RX      = rxReg;
  assign SPI_DONE    = doneReg;
  assign Busy        = (state != ST_IDLE);
  assign SPI_CS_n    = csN;
  assign SPI_SCLK    = sclk;
  assign SPI_MOSI    = mosi;
  assign DebugExport = {22'b0, state, bitCount, sclk};

endmodule

// File: tb/tb_uengine_spi_master.sv
module tb_uengine_spi_master;
  localparam int NI = 3;  // instance 0: H=4, 1: H=1, 2: H=2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0][31:0] tx, misoWord, dbg;
  logic [NI-1:0][15:0] rx;
  logic [NI-1:0] start, miso, done, busy, csN, sclk, mosi;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    logic [15:0] rx;
    int          cyc;
    logic [31:0] tx;
  } Exp;
  Exp q[$];

  // slave / line observer state
  logic [31:0] mosiCap [NI] = '{default: '0};
  int          riseCnt [NI] = '{default: 0};
  int          lowCnt  [NI] = '{default: 0};
  int          lowLast [NI] = '{default: 0};
  int          fallIdx [NI] = '{default: 0};
  logic        prevSclk[NI] = '{default: 1'b0};
  logic        prevCs  [NI] = '{default: 1'b1};

  for (genvar g = 0; g < NI; g++) begin : gu
    localparam int H = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    uengine_spi_master #(.CLK_DIV(H)) dut (
      .SysClock    (clk),
      .SysReset_n  (rst_n),
      .SPI_TX      (tx[g]),
      .SPI_START   (start[g]),
      .SPI_RX      (rx[g]),
      .SPI_DONE    (done[g]),
      .Busy        (busy[g]),
      .SPI_CS_n    (csN[g]),
      .SPI_SCLK    (sclk[g]),
      .SPI_MOSI    (mosi[g]),
      .SPI_MISO    (miso[g]),
      .DebugExport (dbg[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hOf(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mode-0 slave: presents frame bit k after SCLK fall k-1 (bit 1 on CS fall),
  // and records MOSI on every SCLK rise.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (prevCs[g] && !csN[g]) begin
        mosiCap[g] = '0;
        riseCnt[g] = 0;
        lowCnt[g]  = 0;
      end
      if (!csN[g]) lowCnt[g]++;
      if (!prevCs[g] && csN[g]) lowLast[g] = lowCnt[g];
      if (!prevSclk[g] && sclk[g]) begin
        mosiCap[g] = {mosiCap[g][30:0], mosi[g]};
        riseCnt[g]++;
      end
      if (csN[g]) fallIdx[g] = 0;
      else if (prevSclk[g] && !sclk[g] && fallIdx[g] < 31) fallIdx[g]++;
      miso[g]     = misoWord[g][31-fallIdx[g]];
      prevSclk[g] = sclk[g];
      prevCs[g]   = csN[g];
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (done[g]) begin
        if (q.size() == 0) check("spurious_done", done[g], 0);
        else begin
          Exp e;
          e = q.pop_front();
          check("done_inst", g, e.inst);
          check("rx", rx[g], e.rx);
          check("done_cycle", cyc, e.cyc);
          check("mosi_stream", mosiCap[g], e.tx);
          check("sclk_rises", riseCnt[g], 32);
          check("busy_at_done", busy[g], 1);
        end
      end
    end
  end

  task automatic waitIdle(input int g);
    int n = 0;
    @(negedge clk);
    while (busy[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy[g], 0);
  endtask

  task automatic waitDone(input int g, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[g] && n < budget);
    check("done_seen", done[g], 1);
  endtask

  // Expected: RX = last 16 MISO bits of the frame, done 65*H edges after edge 0.
  task automatic issue(input int g, input logic [31:0] t, input logic [31:0] w, input bit push);
    waitIdle(g);
    tx[g]       = t;
    misoWord[g] = w;
    start[g]    = 1'b1;
    if (push) q.push_back('{g, w[15:0], cyc + 1 + 65 * hOf(g), t});
    @(negedge clk);
    start[g] = 1'b0;
    tx[g]    = $urandom();
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] w[3];
    logic [2:0]  chip;
    logic [3:0]  eng;
    int c0, n;
    tx = '0; misoWord = '0; start = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_cs_n", csN[g], 1);
      check("rst_sclk", sclk[g], 0);
      check("rst_mosi", mosi[g], 0);
      check("rst_rx", rx[g], 0);
      check("rst_done", done[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_debug", dbg[g], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Read frame, H=4
    issue(0, 32'hA500_0000, {16'($urandom()), 16'h0002}, 1);
    waitDone(0, 400);

    // Random frames on all three dividers
    for (int i = 0; i < 6; i++) begin
      issue(i % NI, $urandom(), $urandom(), 1);
      waitDone(i % NI, 400);
    end

    // Write frame, H=1, MISO tied high
    issue(1, 32'h1234_BEEF, 32'hFFFF_FFFF, 1);
    waitDone(1, 100);
    @(negedge clk);
    check("cs_low_cycles", lowLast[1], 65);

    // Back-to-back, H=2: frame period = 65*H + DONE cycle + IDLE cycle
    waitIdle(2);
    t = $urandom();
    for (int k = 0; k < 3; k++) w[k] = $urandom();
    tx[2] = t; misoWord[2] = w[0]; start[2] = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 3; k++) q.push_back('{2, w[k][15:0], c0 + 130 + k * 132, t});
    waitDone(2, 400);
    misoWord[2] = w[1];
    n = 0;
    while (csN[2] && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("cs_gap_cycles", n, 2);
    waitDone(2, 400);
    misoWord[2] = w[2];
    waitDone(2, 400);
    start[2] = 1'b0;

    // START while busy, H=4
    issue(0, $urandom(), $urandom(), 1);
    repeat (9) @(negedge clk);
    check("busy_c10", busy[0], 1);
    start[0] = 1'b1; tx[0] = $urandom();
    @(negedge clk);
    start[0] = 1'b0;
    repeat (89) @(negedge clk);
    check("busy_c100", busy[0], 1);
    start[0] = 1'b1; tx[0] = $urandom();
    @(negedge clk);
    start[0] = 1'b0;
    waitDone(0, 400);
    repeat (300) @(negedge clk);

    // Reset mid-frame, H=4 (no completion expected)
    issue(0, $urandom(), {16'($urandom()), 16'h5A5A}, 0);
    repeat (119) @(negedge clk);
    check("busy_pre_reset", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", csN[0], 1);
    check("mid_rst_sclk", sclk[0], 0);
    check("mid_rst_mosi", mosi[0], 0);
    check("mid_rst_rx", rx[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_done", done[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    issue(0, $urandom(), $urandom(), 1);
    waitDone(0, 400);

    // Field mapping: read, chip 101, engine C, register 00
    chip = 3'b101; eng = 4'hC;
    t = (32'd1 << 31) | (32'(chip) << 28) | (32'(eng) << 24) | (32'h00 << 16) | 32'($urandom_range(0, 65535));
    issue(0, t, $urandom(), 1);
    waitDone(0, 400);
    check("field_first8", mosiCap[0][31:24], {1'b1, chip, eng});

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
